// File: rtl/mem_port_arbiter.sv
// Single-port data memory arbiter for CPU MEM stage, UART loader and VGA reader.
// Optional perf counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_mode,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  uart_req,
  input  logic [ADDR_WIDTH-1:0] uart_addr,
  input  logic [DATA_WIDTH-1:0] uart_wdata,
  output logic                  uart_gnt,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_gnt,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic                  vga_rvalid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            owner,
  output logic [15:0]           perf_cpu_stall_cnt,
  output logic [15:0]           perf_vga_force_cnt
);

  // Handshake: req is a level held by the requester together with its
  // address/data until gnt is seen high in the same cycle; gnt means the
  // access reached the memory port this cycle, and nothing is latched here.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_VGA  = 2'd2
  } rd_tag_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]            starve_cnt;
  rd_tag_t               rd_tag;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] vga_rdata_q;
  logic                  ureq;
  logic                  vga_starved;

  assign ureq        = uart_req & uart_mode;
  assign vga_starved = (starve_cnt >= LIMIT);

  // No grant during reset so a reset cycle can never write memory.
  always_comb begin
    cpu_gnt  = 1'b0;
    uart_gnt = 1'b0;
    vga_gnt  = 1'b0;
    owner    = 2'd0;
    if (!rst) begin
      if (ureq) begin
        uart_gnt = 1'b1;
        owner    = 2'd2;
      end else if (vga_req && vga_starved) begin
        vga_gnt = 1'b1;
        owner   = 2'd3;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
        owner   = 2'd1;
      end else if (vga_req) begin
        vga_gnt = 1'b1;
        owner   = 2'd3;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (uart_gnt) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = uart_addr;
      mem_wdata = uart_wdata;
    end else if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (vga_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = vga_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt  <= 4'd0;
      rd_tag      <= TAG_NONE;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
    end else begin
      if (vga_gnt || !vga_req) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt < LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      if (cpu_gnt && !cpu_we) begin
        rd_tag <= TAG_CPU;
      end else if (vga_gnt) begin
        rd_tag <= TAG_VGA;
      end else begin
        rd_tag <= TAG_NONE;
      end
      cpu_rdata_q <= cpu_rdata;
      vga_rdata_q <= vga_rdata;
    end
  end

  // The memory read register supplies the data; the hold registers keep
  // each requester's last word when it is not the one being returned.
  assign cpu_rvalid = (rd_tag == TAG_CPU) & ~rst;
  assign vga_rvalid = (rd_tag == TAG_VGA) & ~rst;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign vga_rdata  = vga_rvalid ? mem_rdata : vga_rdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic vga_forced;
  assign vga_forced = vga_gnt & vga_starved;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cpu_stall_cnt <= 16'd0;
      perf_vga_force_cnt <= 16'd0;
    end else begin
      if (cpu_stall && (perf_cpu_stall_cnt != 16'hFFFF)) begin
        perf_cpu_stall_cnt <= perf_cpu_stall_cnt + 16'd1;
      end
      if (vga_forced && (perf_vga_force_cnt != 16'hFFFF)) begin
        perf_vga_force_cnt <= perf_vga_force_cnt + 16'd1;
      end
    end
  end
`else
  assign perf_cpu_stall_cnt = 16'd0;
  assign perf_vga_force_cnt = 16'd0;
`endif

endmodule
